// File: rtl/uart_rx_core.sv
// UART receive core: oversampled start/data/parity/stop reception with 3-sample
// majority voting, runtime prescale, configurable framing and line-break detection.
module uart_rx_core #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic                      STP2,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      DATA_VALID,
    output logic                      PAR_ERR,
    output logic                      STP_ERR,
    output logic                      BREAK_DET,
    output logic                      BUSY
);

    localparam int PW = PRESCALE_WIDTH;
    localparam int DW = DATA_WIDTH;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE, BRK} state_t;

    state_t          state, next_state;
    logic [PW-1:0]   p_lat, edge_cnt;
    logic            par_en_l, par_typ_l, stp2_l;
    logic [3:0]      bit_cnt;
    logic [1:0]      samp;
    logic [DW-1:0]   data_sr;
    logic            par_acc, par_bad, stp_bad, brk_ok;

    logic [PW-1:0]   p_even, p_sane, mid;
    logic            eval_edge, bit_end, cap0, cap1, vote;
    logic            in_frame, last_data, last_stop, final_eval, is_break, start_entry;

    // Odd ratios are rounded down to even, tiny ratios raised to 8 so mid-1..mid+1 fit in a bit.
    assign p_even    = PRESCALE & ~PW'(1);
    assign p_sane    = (p_even < PW'(8)) ? PW'(8) : p_even;
    assign mid       = p_lat >> 1;
    assign cap0      = (edge_cnt == mid - PW'(1));
    assign cap1      = (edge_cnt == mid);
    assign eval_edge = (edge_cnt == mid + PW'(1));
    assign bit_end   = (edge_cnt == p_lat - PW'(1));
    assign vote      = (samp[0] & samp[1]) | (samp[0] & RX_IN) | (samp[1] & RX_IN);

    assign in_frame    = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);
    assign last_data   = (bit_cnt == 4'(DW - 1));
    assign last_stop   = (bit_cnt == {3'b000, stp2_l});
    assign final_eval  = (state == STOP) && last_stop && eval_edge;
    assign is_break    = brk_ok && !vote;
    assign start_entry = (next_state == START) && (state != START);

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (!RX_IN) next_state = START;
            START: begin
                if (eval_edge && vote) next_state = IDLE;
                else if (bit_end)      next_state = DATA;
            end
            DATA:   if (bit_end && last_data) next_state = par_en_l ? PARITY : STOP;
            PARITY: if (bit_end) next_state = STOP;
            STOP:   if (final_eval) next_state = is_break ? BRK : DONE;
            DONE:   next_state = RX_IN ? IDLE : START;
            BRK:    if (RX_IN) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Counters, sampler, deserializer and per-frame checkers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            p_lat     <= PW'(8);
            par_en_l  <= 1'b0;
            par_typ_l <= 1'b0;
            stp2_l    <= 1'b0;
            edge_cnt  <= '0;
            bit_cnt   <= '0;
            samp      <= '0;
            data_sr   <= '0;
            par_acc   <= 1'b0;
            par_bad   <= 1'b0;
            stp_bad   <= 1'b0;
            brk_ok    <= 1'b1;
        end else if (start_entry) begin
            p_lat     <= p_sane;
            par_en_l  <= PAR_EN;
            par_typ_l <= PAR_TYP;
            stp2_l    <= STP2;
            edge_cnt  <= '0;
            bit_cnt   <= '0;
            par_acc   <= 1'b0;
            par_bad   <= 1'b0;
            stp_bad   <= 1'b0;
            brk_ok    <= 1'b1;
        end else if (in_frame) begin
            edge_cnt <= bit_end ? '0 : edge_cnt + PW'(1);
            if (next_state != state) bit_cnt <= '0;
            else if (bit_end)        bit_cnt <= bit_cnt + 4'd1;
            if (cap0) samp[0] <= RX_IN;
            if (cap1) samp[1] <= RX_IN;
            if (eval_edge) begin
                // Any voted 1 after the start bit rules out a break.
                if (state != START && vote) brk_ok <= 1'b0;
                case (state)
                    DATA: begin
                        data_sr <= {vote, data_sr[DW-1:1]};
                        par_acc <= par_acc ^ vote;
                    end
                    PARITY:  par_bad <= (vote != (par_acc ^ par_typ_l));
                    STOP:    if (!vote) stp_bad <= 1'b1;
                    default: ;
                endcase
            end
        end else begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end
    end

    // DATA_VALID is a one-cycle pulse with no backpressure: the consumer must take
    // P_DATA in that cycle; P_DATA then holds until the next good frame.
    logic [DW-1:0] p_data_d;
    logic          data_valid_d, par_err_d, stp_err_d, break_det_d, busy_d;

    always_comb begin
        p_data_d     = P_DATA;
        data_valid_d = 1'b0;
        par_err_d    = PAR_ERR;
        stp_err_d    = STP_ERR;
        break_det_d  = 1'b0;
        busy_d       = (next_state != IDLE);
        if (start_entry) begin
            par_err_d = 1'b0;
            stp_err_d = 1'b0;
        end
        if (final_eval) begin
            if (is_break) begin
                break_det_d = 1'b1;
                stp_err_d   = 1'b1;
            end else begin
                par_err_d = par_bad;
                stp_err_d = stp_bad | !vote;
                if (!par_bad && !(stp_bad | !vote)) begin
                    data_valid_d = 1'b1;
                    p_data_d     = data_sr;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
            BREAK_DET  <= 1'b0;
            BUSY       <= 1'b0;
        end else begin
            P_DATA     <= p_data_d;
            DATA_VALID <= data_valid_d;
            PAR_ERR    <= par_err_d;
            STP_ERR    <= stp_err_d;
            BREAK_DET  <= break_det_d;
            BUSY       <= busy_d;
        end
    end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Parametrised UART receive core for the UART-RX path of the low-power multi-clock communication system. It replaces the separate RX FSM, edge/bit counters, sampler, deserializer and checkers with one block. Over the previous generation it adds configurable data width, runtime oversampling ratio, odd/even parity, one or two stop bits, 3-sample majority voting and break detection. It runs in the RX clock domain, is fed by an already-synchronised serial line, and drives the RX-side sync/FIFO stage.

## Interface
- DATA_WIDTH, 8: data bits per frame; legal range 5..9.
- PRESCALE_WIDTH, 6: width of the PRESCALE input.
- CLK  input  1  RX oversampling clock.
- RST  input  1  reset, asynchronous, active-low.
- RX_IN  input  1  serial line, synchronised to CLK; idle high.
- PRESCALE  input  PRESCALE_WIDTH  oversampling ratio (CLK cycles per bit).
- PAR_EN  input  1  1 = parity bit present.
- PAR_TYP  input  1  0 = even, 1 = odd.
- STP2  input  1  1 = two stop bits.
- P_DATA  output  DATA_WIDTH  received word, LSB first on the line.
- DATA_VALID  output  1  one-cycle pulse; P_DATA holds a good frame.
- PAR_ERR  output  1  parity mismatch on the last frame.
- STP_ERR  output  1  a stop bit sampled low on the last frame.
- BREAK_DET  output  1  one-cycle pulse; break condition detected.
- BUSY  output  1  high whenever state is not IDLE.

## Operation
- States: IDLE, START, DATA, PARITY, STOP, DONE, BRK.
- Config latch: PRESCALE, PAR_EN, PAR_TYP and STP2 are captured on the IDLE->START transition. Mid-frame changes are ignored.
- PRESCALE sanitising: bit 0 is forced to 0, then values below 8 are clamped to 8. Define P as the latched value and mid = P/2.
- edge_cnt counts 0..P-1 and is 0 in the first START cycle. bit_cnt indexes the current bit within the state.
- Sampling: RX_IN is captured at edge_cnt = mid-1 and mid. At edge_cnt = mid+1 ("evaluation edge") the bit value is the majority of the two captures and the current RX_IN.
- Bit advance: at edge_cnt = P-1, edge_cnt wraps to 0 and the bit advances.
- IDLE: RX_IN = 0 -> START.
- START: at the evaluation edge, a voted value of 1 is a glitch. The block returns to IDLE with no flags or outputs changed. Otherwise it continues to DATA at the bit boundary.
- DATA: each voted bit is shifted in LSB first. After DATA_WIDTH bits the block goes to PARITY if PAR_EN = 1, otherwise to STOP.
- PARITY: the expected value is the XOR of the data bits, inverted when PAR_TYP = 1.
- STOP: one or two stop bits, according to STP2. There is no wait for the end of the final stop bit.
  - On the final stop bit's evaluation edge, go to DONE if no break is detected.
  - If a break is detected, go to BRK instead.
- Break: all data bits are 0, the parity bit (if present) is 0, and every stop bit is 0.
- DONE (one cycle):
  - PAR_ERR and STP_ERR are loaded.
  - DATA_VALID = 1 only if both are 0; P_DATA is loaded only in that case.
  - Next state is START if RX_IN = 0 (back-to-back frame, new config latched, edge_cnt = 0), else IDLE.
- BRK:
  - Entry cycle: BREAK_DET = 1, STP_ERR = 1, DATA_VALID = 0, P_DATA unchanged.
  - The block stays in BRK until RX_IN = 1, then goes to IDLE. The low line is not treated as a start bit.
- Flag lifetime: PAR_ERR and STP_ERR hold their value until the next entry to START, where they clear to 0. PAR_ERR stays 0 when PAR_EN = 0.

## Timing
- Reset values: P_DATA = 0, DATA_VALID = 0, PAR_ERR = 0, STP_ERR = 0, BREAK_DET = 0, BUSY = 0, state IDLE, all counters 0.
- Reset mid-frame returns the block to IDLE immediately. No pulse is emitted.
- All outputs are registered. DATA_VALID, PAR_ERR/STP_ERR updates and BREAK_DET coincide with the DONE or BRK cycle.
- Frame length: N = 1 + DATA_WIDTH + PAR_EN + (STP2 ? 2 : 1).
- Latency: if RX_IN is first seen low in IDLE at cycle t, DONE/BRK occurs at cycle t + 2 + (N-1)*P + mid + 1.
- Example: DATA_WIDTH = 8, no parity, 1 stop, P = 8 gives DONE at t+79.
- BUSY rises the cycle after the start detect. It falls on the cycle the block returns to IDLE.

## Test plan
- Frame 0xA5, 8N1, P = 8 -> DATA_VALID pulse at t+79, P_DATA = 0xA5, PAR_ERR = 0, STP_ERR = 0.
- Frame 0x3C, 8E1, parity bit forced to 1, P = 16 -> DATA_VALID = 0, PAR_ERR = 1, P_DATA unchanged. The next good frame clears PAR_ERR at its START entry.
- 2-cycle low pulse on the idle line, P = 8 -> glitch rejected, return to IDLE. No outputs change; BUSY is high for roughly 6 cycles.
- DATA_WIDTH = 7, odd parity, STP2 = 1, frame 0x55, second stop bit low -> STP_ERR = 1, DATA_VALID = 0.
- Line held low for 20 bit times, 8N1 -> one BREAK_DET pulse with STP_ERR = 1. No further frame is received until the line goes high; a following frame 0x12 is received correctly.
- Two back-to-back frames 0x01 then 0xFE, with no idle gap and PRESCALE changed between them -> two DATA_VALID pulses with correct data. The second frame uses the new P. A single-cycle flip at edge mid of any data bit does not corrupt data.
